uart_packet_parser: RTL and testbench
=====================================

# uart_packet_parser

Framing stage directly downstream of the UART receiver. Consumes the receiver's byte stream (`data`/`data_valid` pulses), hunts for a sync byte, then reads a length byte, payload and checksum. Only checksum-verified payloads are buffered and released through a valid/ready byte stream. Malformed, timed-out or overrunning frames are discarded and reported with an error pulse.

## Interface
Parameters:
- `MaxPayload`, default 16: maximum payload bytes per frame. Legal range 1..255.
- `TimeoutCycles`, default 100000: maximum clk cycles allowed between bytes once a frame has started.

Ports:
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst`  input  1  reset. Synchronous, active-high.
- `rx_data`  input  8  received byte from the UART receiver.
- `rx_data_valid`  input  1  1-cycle strobe; `rx_data` is valid in the same cycle. There is no backpressure.
- `m_data`  output  8  payload byte.
- `m_valid`  output  1  `m_data` is valid.
- `m_ready`  input  1  consumer accepts the byte.
- `m_last`  output  1  marks the final payload byte of the frame; qualified by `m_valid`.
- `pkt_ok`  output  1  1-cycle pulse: a frame passed its checksum.
- `pkt_err`  output  1  1-cycle pulse: a frame was discarded.
- `err_code`  output  2  reason for the discard. Valid while `pkt_err`=1; otherwise holds its last value.

## Operation
- Frame format: SYNC (0xA5), LEN, LEN payload bytes, CSUM.
- Checksum rule: the 8-bit sum, modulo 256, of LEN + payload + CSUM must equal 0x00.
- A byte is accepted in any cycle where `rx_data_valid`=1.
- States:
  - HUNT: discards every byte except 0xA5. On 0xA5, go to LEN.
  - LEN: if LEN=0 or LEN>`MaxPayload`, raise error BAD_LEN and go to HUNT. Otherwise store LEN, set the running sum to LEN, clear the write index, and go to PAYLOAD.
  - PAYLOAD: write the byte to the buffer at the write index, add it to the sum, and increment the index. After the LEN-th byte, go to CSUM.
  - CSUM: if sum+byte == 0 (mod 256), pulse `pkt_ok` and go to DRAIN. Otherwise raise error BAD_CSUM and go to HUNT.
  - DRAIN: presents bytes 0..LEN-1 in order. `m_last`=1 on index LEN-1. After the last handshake (`m_valid`&`m_ready`), go to HUNT.
- Error codes (`err_code`): 0 BAD_LEN, 1 BAD_CSUM, 2 TIMEOUT, 3 OVERRUN.
- Timeout: an idle counter runs in LEN, PAYLOAD and CSUM. It clears on every accepted byte. When it reaches `TimeoutCycles`, raise TIMEOUT and go to HUNT.
- Overrun: any byte arriving in DRAIN is dropped and raises OVERRUN (one pulse per byte). Draining continues unaffected. A 0xA5 arriving in DRAIN is not treated as a sync byte.
- A 0xA5 inside LEN, PAYLOAD or CSUM is ordinary data; there is no resync mid-frame.
- Handshake: once `m_valid` rises, it stays high and `m_data`/`m_last` stay stable until the byte is accepted.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0x00, `pkt_ok`=0, `pkt_err`=0, `err_code`=0. State is HUNT and all counters are 0.
- `rst` asserted mid-frame or mid-drain aborts immediately. The buffer contents are discarded and no error pulse is produced.
- `pkt_ok`/`pkt_err` are registered: they assert in the cycle after the deciding byte strobe (or after the timeout count is reached).
- `m_valid` asserts in the same cycle as `pkt_ok`, carrying payload byte 0 (buffer read is registered, with prefetch).
- Drain throughput: one byte per cycle while `m_ready`=1.
- After the final handshake, the parser is in HUNT on the next cycle and accepts a SYNC strobe arriving that cycle.
- If the deciding byte strobe and the timeout expiry fall in the same cycle, the byte wins.
- Counter widths: payload index and LEN use $clog2(MaxPayload+1) bits; the idle counter uses $clog2(TimeoutCycles+1) bits and saturates.

## Structure
- Shared package `uart_pkg`:
  - `SyncByte` = 8'hA5.
  - `parser_state_t` enum: HUNT, LEN, PAYLOAD, CSUM, DRAIN.
  - `parser_err_t` enum, 2 bits: BAD_LEN, BAD_CSUM, TIMEOUT, OVERRUN.
- Sub-module `uart_pkt_buffer`: `MaxPayload`×8 simple dual-port RAM with a synchronous write port and a registered read port.
- The FSM, checksum, timeout and drain logic stay in the top module.

## Test plan
- Good frame: strobe A5 03 11 22 33 97 with `m_ready`=1 → `pkt_ok` pulse once; `m_data` 11, 22, 33 on consecutive cycles; `m_last` only on 33.
- Bad checksum: A5 03 11 22 33 98 → `pkt_err` with `err_code`=1, no `m_valid`. A following good frame is still received.
- Bad length: A5 00 and, separately, A5 11 with `MaxPayload`=16 → each gives `err_code`=0. The following byte (e.g. A5) re-syncs.
- Backpressure and overrun: good frame with `m_ready` toggling 1,0,0,1 → data held stable while stalled. A byte strobed during DRAIN → `err_code`=3 and the drained payload is intact.
- Timeout: `TimeoutCycles`=50, send A5 02 11 then stall 50 cycles → `err_code`=2. A byte arriving at cycle 49 instead must keep the frame alive.
- Reset mid-PAYLOAD, then send the good frame → correct output with no stale bytes, and no error pulse at reset.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART packet framing stage.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } parser_state_t;

    typedef enum logic [1:0] {
        BAD_LEN  = 2'd0,
        BAD_CSUM = 2'd1,
        TIMEOUT  = 2'd2,
        OVERRUN  = 2'd3
    } parser_err_t;

    // Buffer address width; a single-entry buffer still needs one address bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_buffer
// Brief    : Payload buffer, synchronous write port and registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_pkt_buffer
    import uart_pkg::*;
#(
    parameter int MaxPayload = 16,
    parameter int AW         = addr_w(MaxPayload)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // The read register only advances on request so the presented byte holds during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_parser
// Brief    : Sync/length/payload/checksum framer releasing verified payloads.
// Revision : 1.0 - initial release
// ============================================================================
module uart_packet_parser
    import uart_pkg::*;
#(
    parameter int MaxPayload    = 16,
    parameter int TimeoutCycles = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code
);

    localparam int IW = $clog2(MaxPayload + 1);
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam int MW = addr_w(MaxPayload);
    localparam logic [8:0] c_max_len = 9'(MaxPayload);

    parser_state_t r_state, w_state_nxt;
    parser_err_t   r_err_code, w_err_code_nxt;
    logic          r_pkt_ok, r_pkt_err, w_ok_nxt, w_err_nxt;
    logic [IW-1:0] r_len, r_idx, r_rd_idx;
    logic [7:0]    r_sum, w_sum_fin;
    logic [TW-1:0] r_idle;
    logic          w_in_frame, w_timeout, w_handshake, w_last;
    logic          w_wr_en, w_rd_en;
    logic [MW-1:0] w_rd_addr;

    assign w_sum_fin   = r_sum + rx_data;
    assign w_in_frame  = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CSUM);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign w_timeout   = (r_idle == TW'(TimeoutCycles)) && !rx_data_valid;
    assign m_valid     = (r_state == DRAIN);
    assign w_last      = (r_rd_idx == r_len - IW'(1));
    assign m_last      = m_valid && w_last;
    assign w_handshake = m_valid && m_ready;
    assign pkt_ok      = r_pkt_ok;
    assign pkt_err     = r_pkt_err;
    assign err_code    = r_err_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_pkt_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= BAD_LEN;
        end else begin
            r_state    <= w_state_nxt;
            r_pkt_ok   <= w_ok_nxt;
            r_pkt_err  <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ok_nxt       = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;
        w_wr_en        = 1'b0;
        w_rd_en        = 1'b0;
        w_rd_addr      = r_rd_idx[MW-1:0] + MW'(1);
        case (r_state)
            HUNT: begin
                if (rx_data_valid && rx_data == SyncByte) begin
                    w_state_nxt = LEN;
                end
            end
            LEN: begin
                if (rx_data_valid) begin
                    if (rx_data == 8'h00 || {1'b0, rx_data} > c_max_len) begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = BAD_LEN;
                        w_state_nxt    = HUNT;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = TIMEOUT;
                    w_state_nxt    = HUNT;
                end
            end
            PAYLOAD: begin
                if (rx_data_valid) begin
                    w_wr_en = 1'b1;
                    if (r_idx == r_len - IW'(1)) begin
                        w_state_nxt = CSUM;
                    end
                end else if (w_timeout) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = TIMEOUT;
                    w_state_nxt    = HUNT;
                end
            end
            CSUM: begin
                if (rx_data_valid) begin
                    // Prefetch byte 0 so it is presented together with pkt_ok.
                    w_rd_en   = 1'b1;
                    w_rd_addr = '0;
                    if (w_sum_fin == 8'h00) begin
                        w_ok_nxt    = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = BAD_CSUM;
                        w_state_nxt    = HUNT;
                    end
                end else if (w_timeout) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = TIMEOUT;
                    w_state_nxt    = HUNT;
                end
            end
            DRAIN: begin
                if (rx_data_valid) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = OVERRUN;
                end
                if (w_handshake) begin
                    if (w_last) begin
                        w_state_nxt = HUNT;
                    end else begin
                        w_rd_en = 1'b1;
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len    <= '0;
            r_idx    <= '0;
            r_rd_idx <= '0;
            r_sum    <= 8'h00;
            r_idle   <= '0;
        end else begin
            if (!w_in_frame || rx_data_valid) begin
                r_idle <= '0;
            end else if (r_idle != TW'(TimeoutCycles)) begin
                r_idle <= r_idle + TW'(1);
            end
            case (r_state)
                LEN: begin
                    if (rx_data_valid) begin
                        r_len <= rx_data[IW-1:0];
                        r_sum <= rx_data;
                        r_idx <= '0;
                    end
                end
                PAYLOAD: begin
                    if (rx_data_valid) begin
                        r_sum <= w_sum_fin;
                        r_idx <= r_idx + IW'(1);
                    end
                end
                CSUM: r_rd_idx <= '0;
                DRAIN: begin
                    if (w_handshake && !w_last) begin
                        r_rd_idx <= r_rd_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    uart_pkt_buffer #(
        .MaxPayload(MaxPayload)
    ) u_buffer (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (w_wr_en),
        .wr_addr(r_idx[MW-1:0]),
        .wr_data(rx_data),
        .rd_en  (w_rd_en),
        .rd_addr(w_rd_addr),
        .rd_data(m_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_packet_parser
// Brief    : Scoreboard bench for uart_packet_parser with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_packet_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    // Data entries are {last, byte}; status entries are 4 for pkt_ok, else the error code.
    logic [8:0] dq[$];
    logic [2:0] sq[$];
    logic [7:0] pay [0:15];

    localparam logic [2:0] ST_OK = 3'd4;

    always #5 clk = ~clk;

    uart_packet_parser #(
        .MaxPayload   (16),
        .TimeoutCycles(50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .pkt_ok       (pkt_ok),
        .pkt_err      (pkt_err),
        .err_code     (err_code)
    );

    // Monitor: pops and compares whenever the DUT presents a byte or a status pulse.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] exp_d;
    logic [2:0] exp_s, got_s;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!m_valid || m_data !== prev_data || m_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold got valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b",
                                 m_valid, m_data, m_last, prev_data, prev_last);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                if (m_valid && m_ready) begin
                    checks++;
                    if (dq.size() == 0) begin
                        errors++;
                        $display("FAIL data_unexpected got data=%h last=%0b required none", m_data, m_last);
                    end else begin
                        exp_d = dq.pop_front();
                        if ({m_last, m_data} !== exp_d) begin
                            errors++;
                            $display("FAIL data got data=%h last=%0b required data=%h last=%0b",
                                     m_data, m_last, exp_d[7:0], exp_d[8]);
                        end
                    end
                end
                if (pkt_ok || pkt_err) begin
                    got_s = (pkt_ok && pkt_err) ? 3'd7 : (pkt_ok ? ST_OK : {1'b0, err_code});
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL status_unexpected got %0d required none", got_s);
                    end else begin
                        exp_s = sq.pop_front();
                        if (got_s !== exp_s) begin
                            errors++;
                            $display("FAIL status got %0d required %0d", got_s, exp_s);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        tick(1);
        rx_data_valid = 1'b0;
    endtask

    // Sends SYNC, len, pay[0..len-1], csum; expectations are pushed first.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] csum, input logic [2:0] exp_status);
        if (exp_status == ST_OK) begin
            for (int i = 0; i < int'(len); i++) begin
                dq.push_back({(i == int'(len) - 1), pay[i]});
            end
        end
        sq.push_back(exp_status);
        send_byte(8'hA5);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pay[i]);
        end
        send_byte(csum);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((dq.size() != 0 || sq.size() != 0 || m_valid) && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_wait got pending=%0d/%0d required 0/0", dq.size(), sq.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        m_ready       = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("reset_m_valid", {7'd0, m_valid}, 8'h00);
        chk("reset_m_last", {7'd0, m_last}, 8'h00);
        chk("reset_m_data", m_data, 8'h00);
        chk("reset_pkt_ok", {7'd0, pkt_ok}, 8'h00);
        chk("reset_pkt_err", {7'd0, pkt_err}, 8'h00);
        chk("reset_err_code", {6'd0, err_code}, 8'h00);

        // Good frame
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'h03, 8'h97, ST_OK);
        wait_drain();

        // Bad checksum, then a good frame
        send_frame(8'h03, 8'h98, 3'd1);
        wait_drain();
        send_frame(8'h03, 8'h97, ST_OK);
        wait_drain();

        // Zero length, then over-length immediately followed by a re-syncing good frame
        sq.push_back(3'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        sq.push_back(3'd0);
        send_byte(8'hA5);
        send_byte(8'h11);
        pay[0] = 8'hFF;
        send_frame(8'h01, 8'h00, ST_OK);
        wait_drain();

        // Sync value inside the payload is plain data
        pay[0] = 8'hA5; pay[1] = 8'h10;
        send_frame(8'h02, 8'h49, ST_OK);
        wait_drain();

        // Maximum length frame: 01..10
        for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
        send_frame(8'h10, 8'h68, ST_OK);
        wait_drain();

        // Backpressure 1,0,0,1 with an overrun byte strobed mid-drain
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'h03, 8'h97, ST_OK);
        sq.push_back(3'd3);
        m_ready = 1'b0;
        send_byte(8'hA5);
        tick(1);
        m_ready = 1'b1;
        wait_drain();

        // Timeout after a long stall
        sq.push_back(3'd2);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        tick(60);
        wait_drain();

        // Bytes arriving just inside the timeout window keep the frame alive
        dq.push_back({1'b0, 8'h11});
        dq.push_back({1'b1, 8'h22});
        sq.push_back(ST_OK);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        tick(48);
        send_byte(8'h22);
        tick(48);
        send_byte(8'hCB);
        wait_drain();

        // Reset mid-payload, then a clean frame
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h55);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_mid_m_valid", {7'd0, m_valid}, 8'h00);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'h03, 8'h97, ST_OK);
        wait_drain();
        tick(5);

        checks++;
        if (dq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL queues_empty got %0d/%0d required 0/0", dq.size(), sq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
